// File: rtl/lsu_dport.sv
// lsu_dport: byte-addressed load/store adapter onto a word-wide, byte-enabled synchronous RAM port
module lsu_dport #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_ram_addr,
  output logic [3:0]    o_ram_wen,
  output logic          o_ram_ren,
  output logic [31:0]   o_ram_din,
  input  logic [31:0]   i_ram_dout
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_off, r_size;
  logic        r_uns, r_err;
  logic [31:0] r_rdata;
  logic        w_err, w_go;
  logic [3:0]  w_mask;
  logic [31:0] w_sh, w_ext;
  assign w_err = (i_req_size == 2'd3) || (i_req_size == 2'd1 && i_req_addr[0]) ||
                 (i_req_size == 2'd2 && i_req_addr[1:0] != 2'b00) ||
                 ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH));
  assign w_go   = i_req_valid && r_state == IDLE && !w_err;
  assign w_mask = i_req_size == 2'd0 ? 4'b0001 << i_req_addr[1:0] :
                  i_req_size == 2'd1 ? (i_req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Enables are gated by rst_n so a held request can never write during reset
  assign o_ram_addr = i_req_addr[AW+1:2];
  assign o_ram_wen  = (w_go && i_req_we && rst_n) ? w_mask : 4'b0000;
  assign o_ram_ren  = w_go && !i_req_we && rst_n;
  assign o_ram_din  = i_req_size == 2'd0 ? {4{i_req_wdata[7:0]}} :
                      i_req_size == 2'd1 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
  assign w_sh  = i_ram_dout >> {r_off, 3'b000};
  assign w_ext = r_size == 2'd0 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                 r_size == 2'd1 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = r_state == IDLE    ? (i_req_valid ? ((w_err || i_req_we) ? RESP : RD_WAIT) : IDLE) :
             r_state == RD_WAIT ? RESP : IDLE;
  always_comb begin
    o_req_ready = r_state == IDLE;
    o_rsp_valid = r_state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && i_req_valid) begin
      r_off  <= i_req_addr[1:0];
      r_size <= i_req_size;
      r_uns  <= i_req_unsigned;
      if (w_err || i_req_we) begin
        r_rdata <= 32'h0;
        r_err   <= w_err;
      end
    end else if (r_state == RD_WAIT) begin
      r_rdata <= w_ext;
      r_err   <= 1'b0;
    end
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
endmodule

// File: tb/tb_lsu_dport.sv
// tb_lsu_dport: directed load/store vectors checked against a byte-array memory model
module tb_lsu_dport;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  logic clk = 0, rst_n = 1;
  logic i_req_valid = 0, i_req_we = 0, i_req_unsigned = 0;
  logic [1:0] i_req_size = 0;
  logic [31:0] i_req_addr = 0, i_req_wdata = 0;
  logic o_req_ready, o_rsp_valid, o_rsp_err, o_ram_ren;
  logic [31:0] o_rsp_rdata, o_ram_din, ram_dout;
  logic [AW-1:0] o_ram_addr;
  logic [3:0] o_ram_wen;

  lsu_dport #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_ram_addr(o_ram_addr),
    .o_ram_wen(o_ram_wen), .o_ram_ren(o_ram_ren), .o_ram_din(o_ram_din), .i_ram_dout(ram_dout));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (o_ram_ren) ram_dout <= ram[o_ram_addr];
    for (int b = 0; b < 4; b++) if (o_ram_wen[b]) ram[o_ram_addr][8*b+:8] <= o_ram_din[8*b+:8];
  end

  logic [7:0] mm [4*DEPTH];
  typedef struct {int at; logic [31:0] d; logic e; bit le; logic [31:0] lv;} exp_t;
  exp_t q[$];
  int nchk = 0, nerr = 0, last_acc = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  function automatic void model(input bit we, input logic [1:0] sz, input bit un, input logic [31:0] a,
                                input logic [31:0] wd, output logic e, output logic [31:0] rd,
                                output logic [31:0] dn, output logic [3:0] wn);
    int n = 1 << sz;
    longint v = 0;
    e = (sz == 2'd3) || (a % n != 0) || (a >= 4 * DEPTH);
    rd = 0; dn = 0; wn = 0;
    if (!e) begin
      for (int i = 0; i < 4; i++) dn[8*i+:8] = wd[8*(i%n)+:8];
      if (we) begin
        for (int i = 0; i < n; i++) begin
          wn[a%4+i] = 1'b1;
          mm[a+i] = wd[8*i+:8];
        end
      end else begin
        for (int i = 0; i < n; i++) v = v | (longint'(mm[a+i]) << (8*i));
        if (!un && n < 4 && ((v >> (8*n-1)) & 1) == 1) v = v - (longint'(1) << (8*n));
        rd = v[31:0];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
      chk("rst_ram_en", {27'b0, o_ram_wen, o_ram_ren}, 0);
    end else if (q.size() > 0 && q[0].at == cyc) begin
      chk("rsp_valid", 32'(o_rsp_valid), 1);
      chk("rsp_rdata", o_rsp_rdata, q[0].d);
      chk("rsp_err", 32'(o_rsp_err), 32'(q[0].e));
      if (q[0].le) chk("rsp_rdata_literal", o_rsp_rdata, q[0].lv);
      void'(q.pop_front());
    end else chk("rsp_valid_quiet", 32'(o_rsp_valid), 0);
  end

  task automatic req(bit we, logic [1:0] sz, bit un, logic [31:0] a, logic [31:0] wd,
                     bit le = 0, logic [31:0] lv = 0);
    logic e;
    logic [31:0] rd, dn;
    logic [3:0] wn;
    int k = 0;
    i_req_valid = 1; i_req_we = we; i_req_size = sz; i_req_unsigned = un;
    i_req_addr = a; i_req_wdata = wd;
    #1;
    while (!o_req_ready && k < 20) begin
      chk("busy_ram_en", {27'b0, o_ram_wen, o_ram_ren}, 0);
      @(negedge clk); #1; k++;
    end
    if (!o_req_ready) begin
      nchk++; nerr++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    model(we, sz, un, a, wd, e, rd, dn, wn);
    chk("ram_ren", 32'(o_ram_ren), 32'(!e && !we));
    chk("ram_wen", 32'(o_ram_wen), 32'(wn));
    if (!e) chk("ram_addr", 32'(o_ram_addr), (a >> 2) & 32'hFF);
    if (!e && we) chk("ram_din", o_ram_din, dn);
    q.push_back('{cyc + ((e || we) ? 1 : 2), rd, e, le, lv});
    last_acc = cyc + 1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
    end
  endtask

  int a0, a1, a2;
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 0;
    for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(o_req_ready), 1);
    chk("reset_rdata", o_rsp_rdata, 0);
    chk("reset_err", 32'(o_rsp_err), 0);
    #2 rst_n = 1;
    @(negedge clk);
    req(1, 2, 0, 32'h10, 32'hDEADBEEF, 1, 0);
    chk("sw_wen_literal", 32'(o_ram_wen), 0);
    req(0, 2, 0, 32'h10, 0, 1, 32'hDEADBEEF);
    req(1, 0, 0, 32'h13, 32'h000000A5, 1, 0);
    req(0, 2, 0, 32'h10, 0, 1, 32'hA5ADBEEF);
    req(1, 0, 0, 32'h20, 32'h00000080);
    req(0, 0, 0, 32'h20, 0, 1, 32'hFFFFFF80);
    req(0, 0, 1, 32'h20, 0, 1, 32'h00000080);
    req(1, 1, 0, 32'h22, 32'h00008001);
    req(0, 1, 0, 32'h22, 0, 1, 32'hFFFF8001);
    req(0, 1, 0, 32'h1, 0, 1, 0);
    req(1, 2, 0, 32'h6, 32'h12345678, 1, 0);
    req(0, 3, 0, 32'h0, 0, 1, 0);
    req(0, 2, 0, 32'h400, 0, 1, 0);
    i_req_valid = 0;
    drain();
    chk("err_no_write", ram[1], 0);
    req(0, 2, 0, 32'h10, 0, 1, 32'hA5ADBEEF); a0 = last_acc;
    req(0, 0, 1, 32'h13, 0, 1, 32'h000000A5); a1 = last_acc;
    req(0, 1, 1, 32'h22, 0, 1, 32'h00008001); a2 = last_acc;
    i_req_valid = 0;
    chk("issue_interval_1", 32'(a1 - a0), 3);
    chk("issue_interval_2", 32'(a2 - a1), 3);
    drain();
    req(0, 2, 0, 32'h10, 0);
    i_req_we = 1; i_req_size = 2; i_req_addr = 32'h30; i_req_wdata = 32'hCAFEF00D;
    #2 rst_n = 0;
    q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_ready", 32'(o_req_ready), 1);
    i_req_valid = 0;
    #2 rst_n = 1;
    chk("midrst_no_write", ram[12], 0);
    @(negedge clk);
    chk("post_rst_ready", 32'(o_req_ready), 1);
    req(0, 2, 0, 32'h10, 0, 1, 32'hA5ADBEEF);
    i_req_valid = 0;
    drain();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
